// File: rtl/pipelined_carry_adder.sv
// rtl/pipelined_carry_adder.sv - WIDTH-bit adder split into STAGES registered ripple chunks, valid/ready handshake.
// Optional subtract port enabled by PIPELINED_CARRY_ADDER_SUB_EN.
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    logic             v_r [STAGES];
    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH-1:0] s_r [STAGES];
    logic             c_r [STAGES];
    logic             ovf_r;

    logic [WIDTH-1:0] pa  [STAGES];
    logic [WIDTH-1:0] pb  [STAGES];
    logic [WIDTH-1:0] ps  [STAGES];
    logic             pc  [STAGES];
    logic [WIDTH-1:0] ns  [STAGES];
    logic             nc  [STAGES];
    logic [CHUNK:0]   t   [STAGES];
    logic             msb_cin;
    logic             ovf_n;

    // Global stall: every stage freezes while the output holds an unaccepted result.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        pa[0] = a;
        pb[0] = b_eff;
        ps[0] = '0;
        pc[0] = cin_eff;
        for (int s = 1; s < STAGES; s++) begin
            pa[s] = a_r[s-1];
            pb[s] = b_r[s-1];
            ps[s] = s_r[s-1];
            pc[s] = c_r[s-1];
        end
        // Stage s adds its own chunk; lower chunks ride along unchanged.
        for (int s = 0; s < STAGES; s++) begin
            t[s]  = {1'b0, pa[s][s*CHUNK +: CHUNK]} + {1'b0, pb[s][s*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, pc[s]};
            ns[s] = ps[s];
            ns[s][s*CHUNK +: CHUNK] = t[s][CHUNK-1:0];
            nc[s] = t[s][CHUNK];
        end
        msb_cin = pa[LAST][WIDTH-1] ^ pb[LAST][WIDTH-1] ^ ns[LAST][WIDTH-1];
        ovf_n   = msb_cin ^ nc[LAST];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                v_r[s] <= 1'b0;
                a_r[s] <= '0;
                b_r[s] <= '0;
                s_r[s] <= '0;
                c_r[s] <= 1'b0;
            end
            ovf_r <= 1'b0;
        end else if (adv) begin
            v_r[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) begin
                v_r[s] <= v_r[s-1];
            end
            for (int s = 0; s < STAGES; s++) begin
                a_r[s] <= pa[s];
                b_r[s] <= pb[s];
                s_r[s] <= ns[s];
                c_r[s] <= nc[s];
            end
            ovf_r <= ovf_n;
        end
    end

    assign out_valid = v_r[LAST];
    assign sum       = s_r[LAST];
    assign cout      = c_r[LAST];
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb/tb_pipelined_carry_adder.sv - scoreboard bench for pipelined_carry_adder.
module tb_pipelined_carry_adder;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rand_ready = 0;

    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        exp_t   e;
        longint ux, uy, total;
        logic [W-1:0] yy;
        yy    = sb ? ~y : y;
        ux    = longint'(x);
        uy    = longint'(yy);
        total = ux + uy + longint'(sb ? 1'b1 : ci);
        e.s   = W'(total);
        e.c   = total >= (longint'(1) << W);
        e.o   = (x[W-1] == yy[W-1]) && (e.s[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation for every output handshake, checks stall stability.
    logic held_v = 1'b0;
    exp_t held;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid_held", {31'b0, out_valid}, 32'd1);
                check("stall_data_held", {15'b0, sum, cout, ovf}, {15'b0, held});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: actual sum=%0h with no pending result (cycle %0d)", sum, cyc);
                end else begin
                    e = q.pop_front();
                    check("sum", {16'b0, sum}, {16'b0, e.s});
                    check("cout", {31'b0, cout}, {31'b0, e.c});
                    check("ovf", {31'b0, ovf}, {31'b0, e.o});
                end
            end
            held_v = out_valid && !out_ready;
            held   = {sum, cout, ovf};
        end
    end

    task automatic cycle_drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic ci, input logic sb, output bit acc);
        in_valid = v;
        a = x;
        b = y;
        cin = ci;
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        sub = sb;
`endif
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = v && in_ready && !rst;
        if (acc) q.push_back(model(x, y, ci, sb));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic sb, output int acc_cyc);
        bit acc;
        int n = 0;
        acc = 0;
        while (!acc && n < 100) begin
            cycle_drive(1'b1, x, y, ci, sb, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: operand not accepted in 100 cycles");
        end
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_sum"}, {16'b0, sum}, 32'd0);
        check({tag, "_cout"}, {31'b0, cout}, 32'd0);
        check({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int seen_cyc);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_out_timeout: out_valid never rose");
        end
        seen_cyc = cyc;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_c, seen_c, a0;
        bit acc;
        in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1;
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        sub = 0;
`endif
        do_reset();
        check_reset_state("reset");

        // Carry propagation across all chunks, with latency measurement.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc_c);
        wait_out(seen_c);
        check("latency", seen_c - acc_c + 1, S);
        drain();

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc_c);
        send(16'h0002, 16'hFFFD, 1'b1, 1'b0, acc_c);
        drain();

        // Back-to-back accepts must emerge on consecutive cycles.
        send(16'h0001, 16'h0002, 1'b0, 1'b0, a0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, acc_c);
        check("b2b_accept2", acc_c - a0, 32'd1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, acc_c);
        check("b2b_accept3", acc_c - a0, 32'd2);
        wait_out(seen_c);
        check("b2b_first", seen_c - a0 + 1, S);
        @(negedge clk);
        check("b2b_second_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        check("b2b_third_valid", {31'b0, out_valid}, 32'd1);
        drain();

        // Backpressure with continuous input.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle_drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, acc);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        check("bp_queued", q.size(), S);
        @(posedge clk);
        #1;
        drain();

        // Reset mid-operation discards in-flight work.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, acc_c);
        send(16'h3333, 16'h4444, 1'b1, 1'b0, acc_c);
        send(16'h5555, 16'h6666, 1'b0, 1'b0, acc_c);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("midrst");
        repeat (10) @(posedge clk);
        #1;

`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1, acc_c);
        send(16'h0007, 16'h0005, 1'b1, 1'b1, acc_c);
        drain();
`endif

        // Randomized traffic with random input gaps and output backpressure.
        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            cycle_drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                        1'($urandom),
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
                        1'($urandom),
`else
                        1'b0,
`endif
                        acc);
        end
        rand_ready = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised successor to the team's 4-bit ripple-carry adder.
- Splits a WIDTH-bit add into STAGES ripple-carry chunks. The carry is registered between chunks, giving a throughput of one add per clock.
- Valid/ready handshake on input and output.
- Used as the datapath adder in wide accumulator and address-generation paths, where a full-width combinational carry chain misses timing.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and chunk count; CHUNK = WIDTH/STAGES bits per stage; legal range 1..WIDTH.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A (unsigned/two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry in to bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset: all stage valid flags clear; out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 in the first cycle after reset.
- Pipeline advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
- Accept: on a rising edge with in_valid && in_ready, stage 0 captures:
  - chunk-0 sum of a[CHUNK-1:0] + b[CHUNK-1:0] + cin
  - its carry
  - the remaining upper a/b chunks, skewed forward
- Stage s (1..STAGES-1): on adv, adds chunk s of the skewed operands plus the registered carry from stage s-1. Lower sum chunks already computed are carried forward (deskew), so all WIDTH sum bits leave the last stage together.
- Output register: the last stage register drives sum, cout and ovf.
  - ovf is computed in the last stage from the MSB carry-in and carry-out.
- Latency: STAGES cycles from the accepting edge to out_valid=1. With STAGES=1 the block is a plain registered adder (latency 1).
- Throughput: one transaction per cycle while out_ready=1; back-to-back accepts have no bubbles.
- Bubbles: each stage has a valid flag. Bubbles propagate on adv and are squeezed out when the output is stalled and a downstream stage is empty.
  - Permitted simplification: a global stall (all stages freeze when !adv). Either choice must satisfy the Test Plan.
  - Whichever is chosen, no data loss and no duplication.
- Stall: out_valid=1 && out_ready=0 holds sum/cout/ovf and all in-flight state stable; in_ready=0; in_valid is ignored.
- Simultaneous events:
  - out_ready=1 with in_valid=1 on a full pipeline: the output retires and the input is accepted on the same edge.
- Reset mid-operation: rst overrides everything on that edge. All in-flight transactions are discarded; outputs return to reset values next cycle.
- Arithmetic: wrap-around modulo 2^WIDTH; cout is the unsigned carry; no saturation.
- out_valid deasserts only after a handshake edge (out_valid && out_ready) with no new result behind it. Output data never changes while out_valid=1 and out_ready=0.

Optional Feature:
- Macro PIPELINED_CARRY_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with a/b on accept.
  - sub=1 computes a - b as a + ~b + 1; cin is ignored.
  - cout=1 means no borrow (a >= b unsigned); ovf uses the same signed rule.
  - sub=0 behaves as the base add.
- Undefined: the sub port does not exist; behaviour is add-only as above.

Test Plan:
- Carry propagation (WIDTH=16, STAGES=4): a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> after 4 cycles, out_valid=1, sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x0002, b=0xFFFD, cin=1 -> sum=0x0000, cout=1, ovf=0.
- Back-to-back: issue (1+2), (0x00FF+0x0001), (0x8000+0x8000) on consecutive cycles -> on cycles 4, 5, 6 after the first accept, sums are 0x0003, 0x0100, 0x0000 (last one cout=1, ovf=1), with no gaps.
- Backpressure: hold out_ready=0 for 6 cycles with in_valid=1 continuously -> in_ready=0 once the output is valid, the first result is held stable, nothing is lost. Release out_ready -> results emerge in issue order.
- Reset mid-op: accept 3 transactions, assert rst for 1 cycle at cycle 2 -> next cycle out_valid=0, sum=0, in_ready=1, and no stale results appear afterwards.
- With PIPELINED_CARRY_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
